uart_rx_fifo: RTL

//   Byte buffer directly downstream of the UART receiver.
//   - Captures each received byte, signalled by a 1-cycle data/done strobe, into a DEPTH-entry FIFO.
//   - Presents bytes to the consumer (command parser / CPU bus) on a first-word-fall-through valid/ready port.
//   - Flags bytes lost when the FIFO is full, via a sticky overrun bit.

---
 rtl/uart_pkg.sv | 7 +
 rtl/uart_fifo_mem.sv | 29 ++
 rtl/uart_rx_fifo.sv | 93 +++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared UART constants, used by uart_rx and by the receive FIFO.
//   UART_DATA_W     : width of a received byte
//   UART_FIFO_DEPTH : default number of entries in the receive FIFO
package uart_pkg;
    localparam int UART_DATA_W     = 8;
    localparam int UART_FIFO_DEPTH = 16;
endpackage

// File: rtl/uart_fifo_mem.sv
// Storage for the UART receive FIFO: DEPTH x DATA_W register array.
// There is one synchronous write port and one asynchronous read port.
// Storage is never reset, and readers must qualify rdata with their own valid.
//   clk   : system clock
//   we    : write enable
//   waddr : write address
//   wdata : write data
//   raddr : read address
//   rdata : combinational read of mem[raddr]
module uart_fifo_mem #(
    parameter int DEPTH  = 16,
    parameter int DATA_W = 8,
    parameter int AW     = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              we,
    input  logic [AW-1:0]     waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [AW-1:0]     raddr,
    output logic [DATA_W-1:0] rdata
);
    logic [DATA_W-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we) mem_q[waddr] <= wdata;
    end

    assign rdata = mem_q[raddr];
endmodule

// File: rtl/uart_rx_fifo.sv
// Byte buffer behind the UART receiver.
// Each in_valid strobe pushes in_data into a DEPTH-entry FIFO. The consumer
// reads through a first-word-fall-through valid/ready port. A byte that
// arrives while the FIFO is full, with no pop in the same cycle, is dropped,
// and the sticky overrun flag is set.
//   clk, rst_n        : clock, async active-low reset
//   in_data, in_valid : received byte and 1-cycle push strobe
//   out_data          : head byte, meaningful while out_valid
//   out_valid         : FIFO not empty
//   out_ready         : consumer takes the head byte
//   count             : occupancy 0..DEPTH
//   full              : count == DEPTH
//   overrun           : sticky drop flag
//   overrun_clr       : clears overrun; a same-cycle drop wins over the clear
module uart_rx_fifo
    import uart_pkg::*;
#(
    parameter int DEPTH  = UART_FIFO_DEPTH,
    parameter int DATA_W = UART_DATA_W
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [DATA_W-1:0]        in_data,
    input  logic                     in_valid,
    output logic [DATA_W-1:0]        out_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     overrun,
    input  logic                     overrun_clr
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          overrun_q, overrun_d;
    logic          push, pop, drop;

    // All flags come from registered count only, so in_valid has no
    // combinational path to out_valid or full.
    assign out_valid = (count_q != '0);
    assign full      = (count_q == CW'(DEPTH));
    assign count     = count_q;
    assign overrun   = overrun_q;

    assign pop  = out_valid & out_ready;
    // When full, a push is accepted only because the pop frees a slot this cycle.
    assign push = in_valid & (~full | pop);
    assign drop = in_valid & full & ~pop;

    always_comb begin
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        count_d   = count_q;
        overrun_d = overrun_q;
        // Pointers wrap naturally because DEPTH is a power of two.
        if (push) wr_ptr_d = wr_ptr_q + AW'(1);
        if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
        if (push && !pop)      count_d = count_q + CW'(1);
        else if (pop && !push) count_d = count_q - CW'(1);
        if (overrun_clr) overrun_d = 1'b0;
        if (drop)        overrun_d = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            overrun_q <= 1'b0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            overrun_q <= overrun_d;
        end
    end

    uart_fifo_mem #(
        .DEPTH  (DEPTH),
        .DATA_W (DATA_W)
    ) u_mem (
        .clk   (clk),
        .we    (push),
        .waddr (wr_ptr_q),
        .wdata (in_data),
        .raddr (rd_ptr_q),
        .rdata (out_data)
    );
endmodule
